// File: rtl/fpu_fma_arbiter.sv
`default_nettype none
// ============================================================================
// fpu_fma_arbiter : round-robin share of one FMA unit among NUM_REQ requesters
// Option macro FMA_TIMEOUT_EN adds a WAIT watchdog.   Revision: 1.0
// ============================================================================
module fpu_fma_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ),
  parameter int TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_rs1,
  input  logic [NUM_REQ*32-1:0] req_rs2,
  input  logic [NUM_REQ*32-1:0] req_rs3,
  input  logic [NUM_REQ*2-1:0] req_opcode,
  input  logic [NUM_REQ*3-1:0] req_frm,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [31:0]          rsp_rd,
  output logic                 rsp_nx,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 fma_start,
  output logic [31:0]          fma_rs1,
  output logic [31:0]          fma_rs2,
  output logic [31:0]          fma_rs3,
  output logic [1:0]           fma_opcode,
  output logic [2:0]           fma_frm,
  input  logic [31:0]          fma_rd,
  input  logic                 fma_nx,
  input  logic                 fma_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] w_grant;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_accept;
  logic             w_rsp_hs;
  logic             w_timeout;

  // Scan from the highest offset down so the nearest valid requester wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = IDX_W'((32'(r_rr_ptr) + 32'(k)) % 32'(NUM_REQ));
      if (req_valid[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_accept  = (r_state == IDLE) && w_any;
  assign w_rsp_hs  = (r_state == RESP) && rsp_ready[r_owner];
  assign req_ready = w_accept ? (NUM_REQ'(1) << w_grant) : '0;
  assign rsp_valid = (r_state == RESP) ? (NUM_REQ'(1) << r_owner) : '0;
  assign busy      = (r_state != IDLE);
  assign fma_start = (r_state == ISSUE);

`ifdef FMA_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_wait_cnt;

  assign w_timeout = (r_state == WAIT) && !fma_done &&
                     (r_wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (r_state == ISSUE)
        r_wait_cnt <= '0;
      else if (r_state == WAIT)
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      if (w_accept)
        rsp_err <= 1'b0;
      else if (w_timeout)
        rsp_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // Operands are captured only at accept; the FMA samples rs3/opcode/frm late.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      fma_rs1    <= '0;
      fma_rs2    <= '0;
      fma_rs3    <= '0;
      fma_opcode <= '0;
      fma_frm    <= '0;
      rsp_rd     <= '0;
      rsp_nx     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            fma_rs1    <= req_rs1[32'(w_grant)*32 +: 32];
            fma_rs2    <= req_rs2[32'(w_grant)*32 +: 32];
            fma_rs3    <= req_rs3[32'(w_grant)*32 +: 32];
            fma_opcode <= req_opcode[32'(w_grant)*2 +: 2];
            fma_frm    <= req_frm[32'(w_grant)*3 +: 3];
            r_owner    <= w_grant;
            r_rr_ptr   <= (w_grant == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant + IDX_W'(1);
            r_state    <= ISSUE;
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          if (fma_done) begin
            rsp_rd  <= fma_rd;
            rsp_nx  <= fma_nx;
            r_state <= RESP;
          end else if (w_timeout) begin
            rsp_rd  <= 32'h7FC0_0000;
            rsp_nx  <= 1'b0;
            r_state <= RESP;
          end
        end
        RESP: begin
          if (w_rsp_hs)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_fma_arbiter.sv
`default_nettype none
// Testbench for fpu_fma_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model with an FMA stand-in.
module tb_fpu_fma_arbiter;
  localparam int N = 4;
`ifdef FMA_TIMEOUT_EN
  localparam int TMO    = 16;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 256;
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [31:0] POOL [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000,
                                       32'hBF800000, 32'h40800000, 32'hC0200000, 32'h3E800000};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_rs1, req_rs2, req_rs3;
  logic [N*2-1:0]  req_opcode;
  logic [N*3-1:0]  req_frm;
  logic [31:0]     rsp_rd, fma_rs1, fma_rs2, fma_rs3, fma_rd;
  logic            rsp_nx, rsp_err, busy, fma_start, fma_nx, fma_done;
  logic [1:0]      fma_opcode;
  logic [2:0]      fma_frm;

  always #5 clk = ~clk;

  fpu_fma_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
    .req_opcode(req_opcode), .req_frm(req_frm), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_nx(rsp_nx), .rsp_err(rsp_err),
    .busy(busy), .fma_start(fma_start), .fma_rs1(fma_rs1), .fma_rs2(fma_rs2),
    .fma_rs3(fma_rs3), .fma_opcode(fma_opcode), .fma_frm(fma_frm),
    .fma_rd(fma_rd), .fma_nx(fma_nx), .fma_done(fma_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Exact real <-> binary32 conversion for the small dyadic values used here
  function automatic real from_f(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = 11'(f[30:23]) + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] to_f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic real fma_ref(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c, input logic [1:0] op);
    real p, q;
    p = from_f(a) * from_f(b);
    q = from_f(c);
    case (op)
      2'b00:   return p + q;
      2'b01:   return p - q;
      2'b10:   return -p + q;
      default: return -p - q;
    endcase
  endfunction

  // Requester-side operand store
  logic [31:0] ra [N];
  logic [31:0] rb [N];
  logic [31:0] rc [N];
  logic [1:0]  rop [N];
  logic [2:0]  rfr [N];
  logic [N-1:0] accepted;

  // Model state: 0 idle, 1 issue, 2 wait, 3 respond
  int m_phase, m_ptr, m_owner, m_wcnt;
  logic [31:0] m_a, m_b, m_c, m_rd;
  logic [1:0]  m_op;
  logic [2:0]  m_fr;
  logic        m_nx, m_err;
  int gq[$];

  bit fm_pending, fm_mute, rand_nx;
  int fm_lat;

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_rs1[i*32 +: 32] = ra[i];
      req_rs2[i*32 +: 32] = rb[i];
      req_rs3[i*32 +: 32] = rc[i];
      req_opcode[i*2 +: 2] = rop[i];
      req_frm[i*3 +: 3]    = rfr[i];
    end
  endtask

  task automatic fma_drive();
    fma_done = 1'b0;
    if (fm_pending) begin
      if (fm_lat == 0) begin
        if (!fm_mute) begin
          fma_done   = 1'b1;
          fma_rd     = to_f(fma_ref(fma_rs1, fma_rs2, fma_rs3, fma_opcode));
          fma_nx     = rand_nx ? 1'($urandom_range(0, 1)) : 1'b0;
          fm_pending = 1'b0;
        end
      end else begin
        fm_lat--;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      fma_done = 1'b1;
      fma_rd   = $urandom;
      fma_nx   = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_and_advance();
    bit any;
    int g;
    if (!rst) begin
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_start", 32'(fma_start), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_fma_rs1", fma_rs1, 32'd0);
      check("rst_rsp_rd", rsp_rd, 32'd0);
      m_phase = 0; m_ptr = 0; m_err = 1'b0; fm_pending = 1'b0;
      m_a = '0; m_b = '0; m_c = '0; m_op = '0; m_fr = '0; m_rd = '0; m_nx = 1'b0;
      return;
    end
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("fma_start", 32'(fma_start), 32'(m_phase == 1));
    check("rsp_valid", 32'(rsp_valid), (m_phase == 3) ? (32'd1 << m_owner) : 32'd0);
    check("rsp_err", 32'(rsp_err), 32'(m_err));
    check("rsp_rd", rsp_rd, m_rd);
    check("rsp_nx", 32'(rsp_nx), 32'(m_nx));
    check("fma_rs1", fma_rs1, m_a);
    check("fma_rs2", fma_rs2, m_b);
    check("fma_rs3", fma_rs3, m_c);
    check("fma_op_frm", {27'd0, fma_opcode, fma_frm}, {27'd0, m_op, m_fr});
    any = 1'b0;
    g = 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (!any && req_valid[j]) begin any = 1'b1; g = j; end
    end
    check("req_ready", 32'(req_ready), (m_phase == 0 && any) ? (32'd1 << g) : 32'd0);
    if (fma_start) begin
      fm_pending = 1'b1;
      fm_lat = $urandom_range(0, 4);
    end
    case (m_phase)
      0: if (any) begin
        m_owner = g; gq.push_back(g);
        m_a = ra[g]; m_b = rb[g]; m_c = rc[g]; m_op = rop[g]; m_fr = rfr[g];
        m_ptr = (g + 1) % N; m_err = 1'b0; accepted[g] = 1'b1; m_phase = 1;
      end
      1: begin m_phase = 2; m_wcnt = 0; end
      2: if (fma_done) begin
        m_rd = to_f(fma_ref(m_a, m_b, m_c, m_op)); m_nx = fma_nx; m_phase = 3;
      end else if (TMO_EN && m_wcnt == TMO - 1) begin
        m_rd = 32'h7FC00000; m_nx = 1'b0; m_err = 1'b1; m_phase = 3; fm_pending = 1'b0;
      end else begin
        m_wcnt++;
      end
      default: if (rsp_ready[m_owner]) m_phase = 0;
    endcase
  endtask

  task automatic cycle();
    fma_drive();
    pack();
    #1;
    check_and_advance();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [1:0] op);
    ra[i] = a; rb[i] = b; rc[i] = c; rop[i] = op; rfr[i] = 3'b000;
  endtask

  task automatic wait_grant(input string tag);
    int n0, n;
    n0 = gq.size(); n = 0;
    while (gq.size() == n0 && n < 100) begin cycle(); n++; end
    if (n >= 100) check({tag, "_grant_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (rsp_valid == '0 && n < 100) begin cycle(); n++; end
    if (n >= 100) check({tag, "_rsp_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0;
    rsp_ready = '1;
    cycle();
    while (m_phase != 0 && n < 200) begin cycle(); n++; end
    if (n >= 200) check("drain_timeout", 32'd1, 32'd0);
    accepted = '0;
  endtask

  initial begin
    req_valid = '0; rsp_ready = '0; accepted = '0;
    fma_done = 1'b0; fma_rd = '0; fma_nx = 1'b0;
    fm_pending = 1'b0; fm_mute = 1'b0; rand_nx = 1'b0; fm_lat = 0;
    m_phase = 0; m_ptr = 0; m_owner = 0; m_wcnt = 0; m_err = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, '0, '0, '0, 2'b00);
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b1;

    // Fairness: all requesters valid, grants rotate from index 0
    for (int i = 0; i < N; i++) set_req(i, 32'h3F800000, 32'h3F800000, 32'h3F800000, 2'b00);
    req_valid = '1; rsp_ready = '1;
    gq.delete();
    for (int k = 0; k < 6; k++) wait_grant("fair");
    for (int k = 0; k < 6; k++)
      check($sformatf("fair_grant%0d", k), 32'(gq[k]), 32'(k % 4));
    check("fair_rd", rsp_rd, 32'h40000000);
    drain();

    // Single op from requester 0 (pointer no longer at 0)
    set_req(0, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b00);
    req_valid = 4'b0001; rsp_ready = '0;
    wait_grant("single");
    req_valid = '0;
    wait_rsp("single");
    check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_rd", rsp_rd, 32'h40A00000);
    check("single_nx", 32'(rsp_nx), 32'd0);
    drain();

    // Backpressure on requester 2 while requester 1 waits
    set_req(2, 32'h40000000, 32'h40400000, 32'h3F800000, 2'b11);
    set_req(1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 2'b00);
    req_valid = 4'b0100; rsp_ready = 4'b1011;
    wait_grant("bp");
    req_valid = 4'b0010;
    wait_rsp("bp");
    for (int k = 0; k < 10; k++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'h4);
      check("bp_rd", rsp_rd, 32'hC0E00000);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      cycle();
    end
    rsp_ready = '1;
    wait_grant("bp_next");
    check("bp_next_grant", 32'(gq[gq.size()-1]), 32'd1);
    drain();

    // Operand stability: requester drops rs3 right after accept
    set_req(0, 32'h40000000, 32'h40000000, 32'h40400000, 2'b00);
    req_valid = 4'b0001; rsp_ready = '0;
    wait_grant("stab");
    rc[0] = 32'h0; req_valid = '0;
    wait_rsp("stab");
    check("stab_rs3", fma_rs3, 32'h40400000);
    check("stab_rd", rsp_rd, 32'h40E00000);
    drain();

`ifdef FMA_TIMEOUT_EN
    // Watchdog: FMA never completes
    fm_mute = 1'b1;
    set_req(3, 32'h3F800000, 32'h3F800000, 32'h3F800000, 2'b00);
    req_valid = 4'b1000; rsp_ready = '0;
    wait_grant("tmo");
    req_valid = '0;
    wait_rsp("tmo");
    check("tmo_rd", rsp_rd, 32'h7FC00000);
    check("tmo_err", 32'(rsp_err), 32'd1);
    fm_mute = 1'b0;
    for (int k = 0; k < 8; k++) cycle();
    check("tmo_hold_rd", rsp_rd, 32'h7FC00000);
    drain();
`endif

    // Random traffic
    rand_nx = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (accepted[i]) begin req_valid[i] = 1'b0; accepted[i] = 1'b0; end
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1;
            set_req(i, POOL[$urandom_range(0, 7)], POOL[$urandom_range(0, 7)],
                    POOL[$urandom_range(0, 7)], 2'($urandom_range(0, 3)));
            rfr[i] = 3'($urandom_range(0, 7));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = N'($urandom);
      cycle();
    end
    drain();
    rand_nx = 1'b0;

    // Reset during WAIT, then a fresh request set starts from requester 0
    for (int i = 0; i < N; i++) set_req(i, 32'h3F800000, 32'h3F800000, 32'h3F800000, 2'b00);
    req_valid = '1; rsp_ready = '0;
    begin
      int n;
      n = 0;
      while (m_phase != 2 && n < 100) begin cycle(); n++; end
      if (n >= 100) check("rstmid_wait_timeout", 32'd1, 32'd0);
    end
    check("rstmid_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    gq.delete();
    rsp_ready = '1;
    wait_grant("rstmid");
    check("rstmid_grant", 32'(gq[0]), 32'd0);
    wait_rsp("rstmid");
    check("rstmid_rd", rsp_rd, 32'h40000000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%h exp=%h", 32'd1, 32'd0);
    $fatal(1);
  end

endmodule
`default_nettype wire
